// File: rtl/noc_pkg.sv
// Purpose: flit field layout helpers and skid-buffer state type shared by NoC endpoints and switches.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package noc_pkg;

    // Widest flit the extract helper handles; callers zero-extend into this.
    localparam int NocMaxWidth = 64;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // Flit layout, MSB first: dest | src | payload.
    function automatic int dest_lsb(input int data_width, input int addr_width);
        return data_width - addr_width;
    endfunction

    function automatic int src_lsb(input int data_width, input int addr_width);
        return data_width - 2 * addr_width;
    endfunction

    // Returns the addr_width-bit field starting at lsb, zero-extended.
    function automatic logic [NocMaxWidth-1:0] flit_field(input logic [NocMaxWidth-1:0] flit,
                                                          input int lsb,
                                                          input int addr_width);
        return (flit >> lsb) & ((64'd1 << addr_width) - 64'd1);
    endfunction

endpackage

// File: rtl/noc_skid_buffer.sv
// Purpose: 2-entry skid buffer; ports i_data/i_valid/o_ready upstream, o_data/o_valid/i_ready downstream.
// Latency: 1 cycle from accept to o_valid; sustains 1 item/cycle.
// Backpressure: o_ready is registered and drops once both entries are occupied.
module noc_skid_buffer
    import noc_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [Width-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [Width-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    skid_state_e      state_q;
    logic [Width-1:0] head_q;
    logic [Width-1:0] tail_q;
    logic             rdy_q;
    logic             vld_q;

    logic push;
    logic pop;

    assign push    = i_valid & rdy_q;
    assign pop     = vld_q & i_ready;
    assign o_ready = rdy_q;
    assign o_valid = vld_q;
    assign o_data  = head_q;

    // head_q always holds the oldest item, so o_data is a plain register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= SKID_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    rdy_q <= 1'b1;
                    if (push) begin
                        head_q  <= i_data;
                        state_q <= SKID_ONE;
                        vld_q   <= 1'b1;
                    end else begin
                        vld_q <= 1'b0;
                    end
                end
                SKID_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            tail_q  <= i_data;
                            state_q <= SKID_FULL;
                            rdy_q   <= 1'b0;
                            vld_q   <= 1'b1;
                        end
                        2'b01: begin
                            state_q <= SKID_EMPTY;
                            rdy_q   <= 1'b1;
                            vld_q   <= 1'b0;
                        end
                        2'b11: begin
                            head_q <= i_data;
                            rdy_q  <= 1'b1;
                            vld_q  <= 1'b1;
                        end
                        default: begin
                            rdy_q <= 1'b1;
                            vld_q <= 1'b1;
                        end
                    endcase
                end
                SKID_FULL: begin
                    // No push possible here: rdy_q is low.
                    vld_q <= 1'b1;
                    if (pop) begin
                        head_q  <= tail_q;
                        state_q <= SKID_ONE;
                        rdy_q   <= 1'b1;
                    end else begin
                        rdy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= SKID_EMPTY;
                    rdy_q   <= 1'b0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/noc_pe_interface.sv
// Purpose: PE <-> tree-switch leaf adapter; TX packs {dest,src,payload}, RX filters on dest and strips header.
// Ports: PE TX (i_pe_*/o_pe_ready), switch TX (o_data*/i_data_ready), switch RX (i_data*/o_data_ready),
//        PE RX (o_pe_data/src/valid, i_pe_ready), status counters (o_tx/rx/misroute_count).
// Latency: 1 cycle each direction; backpressure absorbs 2 flits per direction, all ready/valid registered.
module noc_pe_interface
    import noc_pkg::*;
#(
    parameter int DataWidth  = 36,
    parameter int AddrWidth  = 4,
    parameter int MyAddr     = 0,
    parameter int CountWidth = 16
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic [DataWidth-2*AddrWidth-1:0]  i_pe_data,
    input  logic [AddrWidth-1:0]              i_pe_dest,
    input  logic                              i_pe_valid,
    output logic                              o_pe_ready,
    output logic [DataWidth-1:0]              o_data,
    output logic                              o_data_valid,
    input  logic                              i_data_ready,
    input  logic [DataWidth-1:0]              i_data,
    input  logic                              i_data_valid,
    output logic                              o_data_ready,
    output logic [DataWidth-2*AddrWidth-1:0]  o_pe_data,
    output logic [AddrWidth-1:0]              o_pe_src,
    output logic                              o_pe_valid,
    input  logic                              i_pe_ready,
    output logic [CountWidth-1:0]             o_tx_count,
    output logic [CountWidth-1:0]             o_rx_count,
    output logic [CountWidth-1:0]             o_misroute_count
);

    localparam int PayloadWidth = DataWidth - 2 * AddrWidth;
    localparam int DestLsb      = dest_lsb(DataWidth, AddrWidth);
    localparam int SrcLsb       = src_lsb(DataWidth, AddrWidth);
    localparam logic [AddrWidth-1:0] MyAddrL = AddrWidth'(MyAddr);

    // ---------------- TX path ----------------
    logic [DataWidth-1:0] tx_flit;
    assign tx_flit = {i_pe_dest, MyAddrL, i_pe_data};

    noc_skid_buffer #(.Width(DataWidth)) u_tx_buf (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_data   (tx_flit),
        .i_valid  (i_pe_valid),
        .o_ready  (o_pe_ready),
        .o_data   (o_data),
        .o_valid  (o_data_valid),
        .i_ready  (i_data_ready)
    );

    // ---------------- RX path ----------------
    logic [AddrWidth-1:0]              rx_dest;
    logic [AddrWidth-1:0]              rx_src;
    logic                              rx_hit;
    logic [PayloadWidth+AddrWidth-1:0] rx_entry;
    logic [PayloadWidth+AddrWidth-1:0] rx_head;
    logic                              rx_drop;

    assign rx_dest  = AddrWidth'(flit_field(NocMaxWidth'(i_data), DestLsb, AddrWidth));
    assign rx_src   = AddrWidth'(flit_field(NocMaxWidth'(i_data), SrcLsb, AddrWidth));
    assign rx_hit   = (rx_dest == MyAddrL);
    assign rx_entry = {rx_src, i_data[PayloadWidth-1:0]};
    // Misrouted flits share the same ready, so they are swallowed only when the buffer could take a flit.
    assign rx_drop  = i_data_valid & o_data_ready & ~rx_hit;

    noc_skid_buffer #(.Width(PayloadWidth + AddrWidth)) u_rx_buf (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_data   (rx_entry),
        .i_valid  (i_data_valid & rx_hit),
        .o_ready  (o_data_ready),
        .o_data   (rx_head),
        .o_valid  (o_pe_valid),
        .i_ready  (i_pe_ready)
    );

    assign o_pe_src  = rx_head[PayloadWidth +: AddrWidth];
    assign o_pe_data = rx_head[PayloadWidth-1:0];

    // ---------------- status counters ----------------
    logic [CountWidth-1:0] tx_cnt_q, tx_cnt_d;
    logic [CountWidth-1:0] rx_cnt_q, rx_cnt_d;
    logic [CountWidth-1:0] mis_cnt_q, mis_cnt_d;

    always_comb begin
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (o_data_valid && i_data_ready) tx_cnt_d = tx_cnt_q + 1'b1;
        if (o_pe_valid && i_pe_ready)     rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_drop && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign o_tx_count       = tx_cnt_q;
    assign o_rx_count       = rx_cnt_q;
    assign o_misroute_count = mis_cnt_q;

endmodule

// File: tb/tb_noc_pe_interface.sv
module tb_noc_pe_interface;

    localparam int DW = 36;
    localparam int AW = 4;
    localparam int PW = 28;
    localparam int ME = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [PW-1:0] pe_data_in;
    logic [AW-1:0] pe_dest_in;
    logic          pe_valid_in;
    logic          data_ready_in;
    logic [DW-1:0] data_in;
    logic          data_valid_in;
    logic          pe_ready_in;

    logic          pe_ready_o, data_valid_o, data_ready_o, pe_valid_o;
    logic [DW-1:0] data_o;
    logic [PW-1:0] pe_data_o;
    logic [AW-1:0] pe_src_o;
    logic [15:0]   tx_cnt_o, rx_cnt_o, mis_cnt_o;

    // Narrow-counter instance on the same stimulus, for wrap/saturation.
    logic          s_pe_ready, s_data_valid, s_data_ready, s_pe_valid;
    logic [DW-1:0] s_data;
    logic [PW-1:0] s_pe_data;
    logic [AW-1:0] s_pe_src;
    logic [3:0]    s_tx_cnt, s_rx_cnt, s_mis_cnt;

    noc_pe_interface #(.DataWidth(DW), .AddrWidth(AW), .MyAddr(ME), .CountWidth(16)) u_dut (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_pe_data(pe_data_in), .i_pe_dest(pe_dest_in), .i_pe_valid(pe_valid_in), .o_pe_ready(pe_ready_o),
        .o_data(data_o), .o_data_valid(data_valid_o), .i_data_ready(data_ready_in),
        .i_data(data_in), .i_data_valid(data_valid_in), .o_data_ready(data_ready_o),
        .o_pe_data(pe_data_o), .o_pe_src(pe_src_o), .o_pe_valid(pe_valid_o), .i_pe_ready(pe_ready_in),
        .o_tx_count(tx_cnt_o), .o_rx_count(rx_cnt_o), .o_misroute_count(mis_cnt_o)
    );

    noc_pe_interface #(.DataWidth(DW), .AddrWidth(AW), .MyAddr(ME), .CountWidth(4)) u_small (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_pe_data(pe_data_in), .i_pe_dest(pe_dest_in), .i_pe_valid(pe_valid_in), .o_pe_ready(s_pe_ready),
        .o_data(s_data), .o_data_valid(s_data_valid), .i_data_ready(data_ready_in),
        .i_data(data_in), .i_data_valid(data_valid_in), .o_data_ready(s_data_ready),
        .o_pe_data(s_pe_data), .o_pe_src(s_pe_src), .o_pe_valid(s_pe_valid), .i_pe_ready(pe_ready_in),
        .o_tx_count(s_tx_cnt), .o_rx_count(s_rx_cnt), .o_misroute_count(s_mis_cnt)
    );

    // Reference model: each direction is a FIFO of capacity 2.
    bit            live;
    logic [DW-1:0] txq[$];
    logic [31:0]   rxq[$];
    int unsigned   m_tx, m_rx, m_mis, m_stx, m_srx, m_smis;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("pe_ready", pe_ready_o, live && txq.size() < 2);
        chk("data_valid", data_valid_o, txq.size() != 0);
        if (txq.size() != 0) chk("data", data_o, txq[0]);
        if (!live) chk("data_rst", data_o, 0);
        chk("data_ready", data_ready_o, live && rxq.size() < 2);
        chk("pe_valid", pe_valid_o, rxq.size() != 0);
        if (rxq.size() != 0) begin
            chk("pe_src", pe_src_o, rxq[0][31:28]);
            chk("pe_data", pe_data_o, rxq[0][27:0]);
        end
        if (!live) chk("pe_rst", {pe_src_o, pe_data_o}, 0);
        chk("tx_count", tx_cnt_o, m_tx);
        chk("rx_count", rx_cnt_o, m_rx);
        chk("mis_count", mis_cnt_o, m_mis);
        chk("s_tx_count", s_tx_cnt, m_stx);
        chk("s_rx_count", s_rx_cnt, m_srx);
        chk("s_mis_count", s_mis_cnt, m_smis);
    endtask

    // Apply one cycle of inputs, advance the model over the edge, then check.
    task automatic step(input logic rstn, input logic pvld, input logic [PW-1:0] pdat,
                        input logic [AW-1:0] pdest, input logic drdy, input logic [DW-1:0] rdat,
                        input logic rvld, input logic prdy);
        bit tx_acc, tx_pop, rx_acc, rx_pop, hit;
        reset_n = rstn; pe_valid_in = pvld; pe_data_in = pdat; pe_dest_in = pdest;
        data_ready_in = drdy; data_in = rdat; data_valid_in = rvld; pe_ready_in = prdy;
        if (!rstn) begin
            txq.delete(); rxq.delete(); live = 0;
            m_tx = 0; m_rx = 0; m_mis = 0; m_stx = 0; m_srx = 0; m_smis = 0;
        end else begin
            tx_acc = pvld && live && txq.size() < 2;
            tx_pop = drdy && txq.size() != 0;
            rx_acc = rvld && live && rxq.size() < 2;
            rx_pop = prdy && rxq.size() != 0;
            hit    = (rdat[35:32] == AW'(ME));
            if (tx_pop) begin
                void'(txq.pop_front());
                m_tx = (m_tx + 1) % 65536; m_stx = (m_stx + 1) % 16;
            end
            if (tx_acc) txq.push_back({pdest, 4'(ME), pdat});
            if (rx_pop) begin
                void'(rxq.pop_front());
                m_rx = (m_rx + 1) % 65536; m_srx = (m_srx + 1) % 16;
            end
            if (rx_acc && hit) rxq.push_back(rdat[31:0]);
            if (rx_acc && !hit) begin
                if (m_mis < 65535) m_mis++;
                if (m_smis < 15) m_smis++;
            end
            live = 1;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic drdy, input logic prdy);
        step(1'b1, 1'b0, '0, '0, drdy, '0, 1'b0, prdy);
    endtask

    initial begin
        logic [DW-1:0] f;
        logic [AW-1:0] d;
        live = 0;
        m_tx = 0; m_rx = 0; m_mis = 0; m_stx = 0; m_srx = 0; m_smis = 0;

        // Reset
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        chk("rst_ready", {pe_ready_o, data_ready_o}, 2'b00);
        idle(1'b1, 1'b1);
        chk("ready_up", {pe_ready_o, data_ready_o}, 2'b11);

        // Directed TX
        step(1'b1, 1'b1, 28'h0ABCDEF, 4'd5, 1'b1, '0, 1'b0, 1'b1);
        chk("tx_flit", data_o, 36'h520ABCDEF);
        idle(1'b1, 1'b1);
        chk("tx_cnt_1", tx_cnt_o, 1);

        // TX backpressure: 3 offered, 2 absorbed
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 28'(32'h100 + i), 4'(i + 1), 1'b0, '0, 1'b0, 1'b1);
        chk("bp_ready_low", pe_ready_o, 0);
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);

        // Directed RX hit and misroute
        step(1'b1, 1'b0, '0, '0, 1'b1, 36'h271234567, 1'b1, 1'b0);
        chk("rx_src", pe_src_o, 7);
        chk("rx_data", pe_data_o, 28'h1234567);
        idle(1'b1, 1'b1);
        chk("rx_cnt_1", rx_cnt_o, 1);
        step(1'b1, 1'b0, '0, '0, 1'b1, 36'h3A0000001, 1'b1, 1'b1);
        chk("mis_cnt_1", mis_cnt_o, 1);
        chk("mis_no_valid", pe_valid_o, 0);

        // Saturation of the narrow misroute counter
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, '0, '0, 1'b1, {4'd9, 32'(i)}, 1'b1, 1'b1);
        chk("s_mis_sat", s_mis_cnt, 4'hF);

        // Random traffic, PE RX ready toggling every cycle
        for (int i = 0; i < 400; i++) begin
            d = ($urandom_range(0, 3) != 0) ? AW'(ME) : AW'($urandom_range(0, 15));
            f = {d, 4'($urandom), 28'($urandom)};
            step(1'b1, 1'($urandom), 28'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0),
                 f, 1'($urandom), 1'(i % 2));
        end
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b1);

        // Fill both buffers, then reset mid-operation
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 28'(32'hA0 + i), 4'd6, 1'b0, {4'(ME), 4'd1, 28'(i)}, 1'b1, 1'b0);
        chk("full_tx", pe_ready_o, 0);
        chk("full_rx", data_ready_o, 0);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        chk("rst_valids", {data_valid_o, pe_valid_o}, 2'b00);
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b1);
        chk("post_rst_cnt", {tx_cnt_o, rx_cnt_o, mis_cnt_o}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
